// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port Data_Memory arbiter.
// Encodings used by mem_arbiter and mem_arb_grant.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 256;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner select for the memory arbiter.
// MEM_ARB_RR_EN: round-robin pointer; otherwise port 1 has fixed priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk_i,
  input  logic rst_i,
  input  logic take_i,
`endif
  input  logic req0_i,
  input  logic req1_i,
  output logic any_o,
  output logic win_o
);

  assign any_o = req0_i | req1_i;

`ifdef MEM_ARB_RR_EN
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    win_o = PORT_I;
    unique case (1'b1)
      (req0_i && req1_i):  win_o = ptr_q;
      (req1_i && !req0_i): win_o = PORT_D;
      default:             win_o = PORT_I;
    endcase
  end

  // Pointer moves off whichever port just won.
  always_comb begin
    ptr_d = ptr_q;
    if (take_i && any_o) begin
      ptr_d = ~win_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= PORT_I;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign win_o = req1_i ? PORT_D : PORT_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port line arbiter in front of Data_Memory (icache / dcache).
// Build option: MEM_ARB_RR_EN selects round-robin over fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  state_e state_q, state_d;
  logic win_q, win_d;
  logic ack0_q, ack0_d;
  logic ack1_q, ack1_d;
  logic en_q, en_d;
  logic wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;

  logic any;
  logic win;

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .take_i (state_q == IDLE),
`endif
    .req0_i (req0_enable_i),
    .req1_i (req1_enable_i),
    .any_o  (any),
    .win_o  (win)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    en_d    = en_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = BUSY;
          win_d   = win;
          en_d    = 1'b1;
          if (win == PORT_D) begin
            wr_d   = req1_write_i;
            addr_d = req1_addr_i;
            wdat_d = req1_data_i;
          end else begin
            wr_d   = req0_write_i;
            addr_d = req0_addr_i;
            wdat_d = req0_data_i;
          end
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d = DONE;
          en_d    = 1'b0;
          ack0_d  = (win_q == PORT_I);
          ack1_d  = (win_q == PORT_D);
          if (!wr_q) begin
            rdat_d = mem_data_i;
          end
        end
      end
      DONE: begin
        // One settle cycle lets the winner drop its enable.
        state_d = IDLE;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      win_q   <= PORT_I;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
    end
  end

  assign req0_ack_o   = ack0_q;
  assign req1_ack_o   = ack1_q;
  assign rdata_o      = rdat_q;
  assign mem_enable_o = en_q;
  assign mem_write_o  = wr_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = wdat_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a Data_Memory model and scoreboard.
// Honours MEM_ARB_RR_EN to pick the expected grant order.
module tb_mem_arbiter;

  typedef struct packed {
    logic        port;
    logic        wr;
    logic [31:0] addr;
    logic [255:0] data;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req0_enable_i, req0_write_i;
  logic [31:0]  req0_addr_i;
  logic [255:0] req0_data_i;
  logic         req0_ack_o;
  logic         req1_enable_i, req1_write_i;
  logic [31:0]  req1_addr_i;
  logic [255:0] req1_data_i;
  logic         req1_ack_o;
  logic [255:0] rdata_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;

  logic [255:0] mem [64];
  logic [255:0] last_rdata;
  exp_t         sb [$];
  int           lat;
  logic         force_ack;
  int           vectors;
  int           miscompares;

  always #5 clk_i = ~clk_i;

  mem_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req0_enable_i (req0_enable_i),
    .req0_write_i  (req0_write_i),
    .req0_addr_i   (req0_addr_i),
    .req0_data_i   (req0_data_i),
    .req0_ack_o    (req0_ack_o),
    .req1_enable_i (req1_enable_i),
    .req1_write_i  (req1_write_i),
    .req1_addr_i   (req1_addr_i),
    .req1_data_i   (req1_data_i),
    .req1_ack_o    (req1_ack_o),
    .rdata_o       (rdata_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i)
  );

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic p, input logic w,
                      input logic [31:0] a,
                      input logic [255:0] d);
    exp_t e;
    e.port = p;
    e.wr   = w;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  function automatic logic ack_of(input logic p);
    return p ? req1_ack_o : req0_ack_o;
  endfunction

  task automatic do_req(input logic p, input logic w,
                        input logic [31:0] a,
                        input logic [255:0] d,
                        input logic chk_lat);
    int n;
    if (p) begin
      req1_write_i = w; req1_addr_i = a;
      req1_data_i = d; req1_enable_i = 1'b1;
    end else begin
      req0_write_i = w; req0_addr_i = a;
      req0_data_i = d; req0_enable_i = 1'b1;
    end
    @(negedge clk_i);
    if (chk_lat) chk("en_latency", mem_enable_o, 1);
    n = 0;
    while (!ack_of(p) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk("ack_seen", n < 300, 1);
    if (chk_lat) chk("ack_latency", n, lat);
    if (p) req1_enable_i = 1'b0;
    else   req0_enable_i = 1'b0;
    @(negedge clk_i);
    if (chk_lat) chk("ack_pulse", ack_of(p), 0);
  endtask

  // Data_Memory model: ack pulse lat cycles into an enable.
  initial begin
    int   cnt;
    logic [5:0] idx;
    cnt = 0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (force_ack) begin
        mem_ack_i = 1'b1;
      end else if (!rst_i || !mem_enable_o) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          idx = mem_addr_o[10:5];
          mem_ack_i = 1'b1;
          mem_data_i = mem[idx];
          if (mem_write_o) mem[idx] = mem_data_o;
        end
      end
    end
  end

  // Scoreboard: every ack must match the oldest expectation.
  initial begin
    exp_t e;
    logic [5:0] idx;
    forever begin
      @(negedge clk_i);
      if (rst_i && (req0_ack_o || req1_ack_o)) begin
        chk("one_ack", req0_ack_o & req1_ack_o, 0);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          idx = e.addr[10:5];
          chk("ack_port", req1_ack_o, e.port);
          chk("mem_addr", mem_addr_o, e.addr);
          chk("mem_write", mem_write_o, e.wr);
          if (e.wr) begin
            chk("rdata_kept", rdata_o, last_rdata);
            chk("mem_written", mem[idx], e.data);
          end else begin
            chk("rdata", rdata_o, mem[idx]);
            last_rdata = mem[idx];
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vectors = 0;
    miscompares = 0;
    last_rdata = '0;
    force_ack = 1'b0;
    lat = 10;
    for (int i = 0; i < 64; i++)
      mem[i] = {8{32'hC0DE_0000 + i}};
    rst_i = 1'b0;
    req0_enable_i = 0; req0_write_i = 0;
    req0_addr_i = 0; req0_data_i = 0;
    req1_enable_i = 0; req1_write_i = 0;
    req1_addr_i = 0; req1_data_i = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_en", mem_enable_o, 0);
    chk("rst_ack0", req0_ack_o, 0);
    chk("rst_ack1", req1_ack_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Single read on port 0.
    push(0, 0, 32'h400, 0);
    do_req(0, 0, 32'h400, 0, 1);

    // Single write on port 1.
    lat = 5;
    push(1, 1, 32'h20, 256'hA5);
    do_req(1, 1, 32'h20, 256'hA5, 1);
    chk("mem1_a5", mem[1], 256'hA5);

    // Contention.
    lat = 4;
`ifdef MEM_ARB_RR_EN
    push(0, 0, 32'h40, 0);
    push(1, 0, 32'h60, 0);
`else
    push(1, 0, 32'h60, 0);
    push(0, 0, 32'h40, 0);
`endif
    fork
      do_req(0, 0, 32'h40, 0, 0);
      do_req(1, 0, 32'h60, 0, 0);
    join

`ifdef MEM_ARB_RR_EN
    // Both ports saturating: strict alternation.
    lat = 2;
    for (int k = 0; k < 3; k++) begin
      push(0, 0, 32'h100 + 32'(k) * 32'h40, 0);
      push(1, 0, 32'h120 + 32'(k) * 32'h40, 0);
    end
    fork
      for (int k = 0; k < 3; k++)
        do_req(0, 0, 32'h100 + 32'(k) * 32'h40, 0, 0);
      for (int j = 0; j < 3; j++)
        do_req(1, 0, 32'h120 + 32'(j) * 32'h40, 0, 0);
    join
`endif

    // Reset in the middle of a transaction.
    lat = 20;
    req0_write_i = 0;
    req0_addr_i = 32'h80;
    req0_enable_i = 1'b1;
    n = 0;
    while (!mem_enable_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("busy_seen", n < 50, 1);
    repeat (3) @(negedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("abort_en", mem_enable_o, 0);
    chk("abort_ack0", req0_ack_o, 0);
    chk("abort_rdata", rdata_o, 0);
    chk("abort_addr", mem_addr_o, 0);
    repeat (2) @(negedge clk_i);
    lat = 3;
    last_rdata = '0;
    push(0, 0, 32'h80, 0);
    #1 rst_i = 1'b1;
    n = 0;
    while (!req0_ack_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("reissue_done", n < 100, 1);
    req0_enable_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Spurious memory ack while idle.
    force_ack = 1'b1;
    @(negedge clk_i);
    force_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("spur_ack0", req0_ack_o, 0);
      chk("spur_ack1", req1_ack_o, 0);
      chk("spur_en", mem_enable_o, 0);
    end
    lat = 3;
    push(1, 0, 32'h400, 0);
    do_req(1, 0, 32'h400, 0, 1);

    repeat (4) @(negedge clk_i);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
